uart_boot_loader: RTL and testbench

//  Receives a load frame from the UART receiver, writes the 16-bit words into external memory as a

---
 rtl/uart_boot_loader.sv | 192 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART frame loader writing words to memory and gating CPU reset
module uart_boot_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_new,
    input  logic        tx_rdy,
    output logic        tx_new,
    output logic [7:0]  tx_char,
    output logic        req,
    input  logic        ack,
    output logic        rw,
    output logic [19:0] adr,
    output logic [15:0] dtw,
    output logic        hold_cpu,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DRAIN,
        S_RESP,
        S_DONE
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;
    localparam logic [7:0]  CH_ACK   = 8'h06;
    localparam logic [7:0]  CH_NAK   = 8'h15;

    state_t      state;
    logic [2:0]  hdr_cnt;
    logic [15:0] len;
    logic [19:0] addr;
    logic [7:0]  sum;
    logic [7:0]  d_hi;
    logic        csum_ok;
    logic        overrun;
    logic        tmo_hit;
    logic [31:0] tmr;
    logic        timed_state;

    // Only the byte-receiving states are subject to the inter-byte timeout.
    assign timed_state = (state == S_HDR) || (state == S_DATA_HI) ||
                         (state == S_DATA_LO) || (state == S_CSUM);

    // Frame parser, memory request handshake, response and inter-byte timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            hdr_cnt  <= 3'd0;
            len      <= 16'd0;
            addr     <= 20'd0;
            sum      <= 8'd0;
            d_hi     <= 8'd0;
            csum_ok  <= 1'b0;
            overrun  <= 1'b0;
            tmo_hit  <= 1'b0;
            tmr      <= 32'd0;
            tx_new   <= 1'b0;
            tx_char  <= 8'd0;
            req      <= 1'b0;
            rw       <= 1'b0;
            adr      <= 20'd0;
            dtw      <= 16'd0;
            hold_cpu <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_new <= 1'b0;

            // Retire the outstanding write; a new word issued below overrides this.
            if (req && ack) begin
                req <= 1'b0;
                rw  <= 1'b0;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (rx_new && rx_data == SYNC_BYTE) begin
                        hold_cpu <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        sum      <= 8'd0;
                        hdr_cnt  <= 3'd0;
                        tmr      <= 32'd0;
                        overrun  <= 1'b0;
                        tmo_hit  <= 1'b0;
                        csum_ok  <= 1'b0;
                        state    <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (rx_new) begin
                        sum     <= sum + rx_data;
                        hdr_cnt <= hdr_cnt + 3'd1;
                        case (hdr_cnt)
                            3'd0: len[15:8]    <= rx_data;
                            3'd1: len[7:0]     <= rx_data;
                            3'd2: addr[19:16]  <= rx_data[3:0];
                            3'd3: addr[15:8]   <= rx_data;
                            default: begin
                                addr[7:0] <= rx_data;
                                state     <= (len == 16'd0) ? S_CSUM : S_DATA_HI;
                            end
                        endcase
                    end
                end

                S_DATA_HI: begin
                    if (rx_new) begin
                        sum   <= sum + rx_data;
                        d_hi  <= rx_data;
                        state <= S_DATA_LO;
                    end
                end

                S_DATA_LO: begin
                    if (rx_new) begin
                        sum <= sum + rx_data;
                        if (req && !ack) begin
                            // Previous write still outstanding: drop this word and abort.
                            overrun <= 1'b1;
                            state   <= S_DRAIN;
                        end else begin
                            req   <= 1'b1;
                            rw    <= 1'b1;
                            adr   <= addr;
                            dtw   <= {d_hi, rx_data};
                            addr  <= addr + 20'd1;
                            len   <= len - 16'd1;
                            state <= (len == 16'd1) ? S_CSUM : S_DATA_HI;
                        end
                    end
                end

                S_CSUM: begin
                    if (rx_new) begin
                        csum_ok <= (rx_data == sum);
                        state   <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (!req) begin
                        state <= tmo_hit ? S_IDLE : S_RESP;
                    end
                end

                S_RESP: begin
                    if (tx_rdy) begin
                        tx_new <= 1'b1;
                        if (csum_ok && !overrun) begin
                            tx_char  <= CH_ACK;
                            done     <= 1'b1;
                            hold_cpu <= 1'b0;
                        end else begin
                            tx_char <= CH_NAK;
                            err     <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end

                default: state <= S_IDLE;
            endcase

            // Inter-byte timeout; takes precedence over the parser's next state.
            if (timed_state) begin
                if (rx_new) begin
                    tmr <= 32'd0;
                end else if (TIMEOUT_CYCLES != 0 && tmr == TMO_LAST) begin
                    err     <= 1'b1;
                    tmo_hit <= 1'b1;
                    tmr     <= 32'd0;
                    state   <= S_DRAIN;
                end else begin
                    tmr <= tmr + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - randomized self-checking bench for uart_boot_loader
module tb_uart_boot_loader;

    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_new;
    logic        tx_rdy;
    logic        tx_new;
    logic [7:0]  tx_char;
    logic        req;
    logic        ack;
    logic        rw;
    logic [19:0] adr;
    logic [15:0] dtw;
    logic        hold_cpu;
    logic        done;
    logic        err;

    uart_boot_loader #(.TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_new(rx_new),
        .tx_rdy(tx_rdy), .tx_new(tx_new), .tx_char(tx_char),
        .req(req), .ack(ack), .rw(rw), .adr(adr), .dtw(dtw),
        .hold_cpu(hold_cpu), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ack_delay = 2;
    int stab_bad  = 0;
    int rw_bad    = 0;

    logic [19:0] wr_adr[$];
    logic [15:0] wr_dat[$];
    logic [7:0]  tx_q[$];

    logic [7:0]  fb[$];
    logic [19:0] ex_adr[$];
    logic [15:0] ex_dat[$];

    // Memory responder: logs each write, checks stability, acks after ack_delay cycles.
    initial begin : responder
        logic [19:0] a;
        logic [15:0] d;
        int n;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (req === 1'b1 && reset === 1'b0) begin
                a = adr;
                d = dtw;
                if (rw !== 1'b1) rw_bad++;
                wr_adr.push_back(a);
                wr_dat.push_back(d);
                n = 0;
                while (n < ack_delay && req === 1'b1) begin
                    @(negedge clk);
                    n++;
                    if (req === 1'b1 && (adr !== a || dtw !== d || rw !== 1'b1)) stab_bad++;
                end
                if (req === 1'b1) begin
                    ack = 1'b1;
                    @(negedge clk);
                    ack = 1'b0;
                end
            end
        end
    end

    // Transmit monitor: each cycle with tx_new high is one sent byte.
    initial begin : tx_mon
        forever begin
            @(negedge clk);
            if (tx_new === 1'b1) tx_q.push_back(tx_char);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data = b;
        rx_new  = 1'b1;
        @(negedge clk);
        rx_new  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(fb[i], $urandom_range(3, 6));
    endtask

    task automatic clear_logs();
        wr_adr = {};
        wr_dat = {};
        tx_q   = {};
        stab_bad = 0;
        rw_bad   = 0;
    endtask

    // Reference model: frame bytes, expected writes (base+i mod 2^20), checksum of bytes after SYNC.
    task automatic make_frame(input logic [19:0] base, input int n, input bit corrupt);
        logic [7:0]  s;
        logic [7:0]  b;
        logic [15:0] w;
        logic [15:0] nn;
        logic [3:0]  junk;
        fb = {};
        ex_adr = {};
        ex_dat = {};
        s  = 8'd0;
        nn = 16'(n);
        junk = 4'($urandom_range(0, 15));
        fb.push_back(8'hA5);
        b = nn[15:8];            fb.push_back(b); s += b;
        b = nn[7:0];             fb.push_back(b); s += b;
        b = {junk, base[19:16]}; fb.push_back(b); s += b;
        b = base[15:8];          fb.push_back(b); s += b;
        b = base[7:0];           fb.push_back(b); s += b;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            ex_adr.push_back(20'((base + 20'(i)) % 21'h100000));
            ex_dat.push_back(w);
            b = w[15:8]; fb.push_back(b); s += b;
            b = w[7:0];  fb.push_back(b); s += b;
        end
        fb.push_back(corrupt ? s + 8'd1 : s);
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tx_q.size() > 0) ok = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_new = 1'b0;
        rx_data = 8'h00;
        tx_rdy = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({req, rw, adr, dtw, tx_new, tx_char, hold_cpu, done, err} !==
            {1'b0, 1'b0, 20'h0, 16'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: req=%b rw=%b adr=%h dtw=%h txn=%b txc=%h hold=%b done=%b err=%b, need 0 0 0 0 0 0 1 0 0",
                     req, rw, adr, dtw, tx_new, tx_char, hold_cpu, done, err);
        end
        reset = 1'b0;
        clear_logs();
        // Non-SYNC bytes in IDLE must be ignored.
        fb = {8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h12, 8'h34, 8'h47};
        send_range(0, 7);
        repeat (20) @(negedge clk);
        total++;
        if (wr_adr.size() != 0 || tx_q.size() != 0 || hold_cpu !== 1'b1) begin
            bad++;
            $display("FAIL idle_ignore: writes=%0d tx=%0d hold=%b, need 0 0 1", wr_adr.size(), tx_q.size(), hold_cpu);
        end
    endtask

    task automatic test_fixed_frame();
        bit ok;
        int nb;
        clear_logs();
        ack_delay = 2;
        fb = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hD0};
        ex_adr = {20'h01000, 20'h01001};
        ex_dat = {16'h1234, 16'hABCD};
        send_range(0, 10);
        wait_resp(ok);
        nb = 0;
        if (wr_adr.size() != 2) nb = 1;
        else foreach (ex_adr[i]) if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i]) nb++;
        total++;
        if (nb != 0) begin
            bad++;
            $display("FAIL fixed_writes: got %0d writes first %h=%h, need 2 writes 01000=1234 01001=abcd",
                     wr_adr.size(), wr_adr[0], wr_dat[0]);
        end
        total++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            bad++;
            $display("FAIL fixed_tx: got %0d bytes first %h, need one 06", tx_q.size(), tx_q[0]);
        end
        total++;
        if ({done, hold_cpu, err} !== 3'b100) begin
            bad++;
            $display("FAIL fixed_flags: done/hold/err=%b%b%b, need 100", done, hold_cpu, err);
        end
        total++;
        if (stab_bad != 0 || rw_bad != 0) begin
            bad++;
            $display("FAIL fixed_handshake: unstable=%0d rw_low=%0d, need 0 0", stab_bad, rw_bad);
        end
    endtask

    task automatic test_bad_csum();
        bit ok;
        clear_logs();
        tx_rdy = 1'b0;
        fb = {8'hA5, 8'h00, 8'h02, 8'h00, 8'h10, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hD1};
        send_range(0, 10);
        repeat (30) @(negedge clk);
        total++;
        if (tx_q.size() != 0 || done !== 1'b0 || hold_cpu !== 1'b1) begin
            bad++;
            $display("FAIL csum_wait_txrdy: tx=%0d done=%b hold=%b, need 0 0 1", tx_q.size(), done, hold_cpu);
        end
        tx_rdy = 1'b1;
        wait_resp(ok);
        total++;
        if (wr_adr.size() != 2 || wr_adr[1] !== 20'h01001 || wr_dat[1] !== 16'hABCD) begin
            bad++;
            $display("FAIL csum_writes: got %0d writes last %h=%h, need 2 ending 01001=abcd",
                     wr_adr.size(), wr_adr[1], wr_dat[1]);
        end
        total++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h15 || {done, hold_cpu, err} !== 3'b011) begin
            bad++;
            $display("FAIL csum_nak: tx=%0d first %h done/hold/err=%b%b%b, need one 15 and 011",
                     tx_q.size(), tx_q[0], done, hold_cpu, err);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        int nb;
        clear_logs();
        fb = {8'hA5, 8'h00, 8'h01, 8'h0F, 8'hFF, 8'hFF, 8'h55, 8'hAA, 8'h0D};
        send_range(0, 8);
        wait_resp(ok);
        total++;
        if (wr_adr.size() != 1 || wr_adr[0] !== 20'hFFFFF || wr_dat[0] !== 16'h55AA || !ok || tx_q[0] !== 8'h06) begin
            bad++;
            $display("FAIL wrap_single: writes=%0d %h=%h tx=%h, need 1 fffff=55aa tx 06",
                     wr_adr.size(), wr_adr[0], wr_dat[0], tx_q[0]);
        end
        clear_logs();
        make_frame(20'hFFFFF, 2, 1'b0);
        send_range(0, fb.size() - 1);
        wait_resp(ok);
        nb = 0;
        if (wr_adr.size() != ex_adr.size()) nb = 1;
        else foreach (ex_adr[i]) if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i]) nb++;
        total++;
        if (nb != 0 || !ok || tx_q[0] !== 8'h06) begin
            bad++;
            $display("FAIL wrap_two: writes=%0d second adr %h tx=%h, need 2 with second 00000 tx 06",
                     wr_adr.size(), wr_adr[1], tx_q[0]);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        fb = {8'hA5, 8'h00, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 5; i++) send_byte(fb[i], 3);
        repeat (150) @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: err=%b before timeout, need 0", err);
        end
        repeat (100) @(negedge clk);
        total++;
        if ({err, hold_cpu, done, req} !== 4'b1100 || tx_q.size() != 0) begin
            bad++;
            $display("FAIL timeout_hit: err/hold/done/req=%b%b%b%b tx=%0d, need 1100 and 0",
                     err, hold_cpu, done, req, tx_q.size());
        end
        fb = {8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h12, 8'h34, 8'h47};
        send_range(0, 7);
        repeat (20) @(negedge clk);
        total++;
        if (wr_adr.size() != 0 || tx_q.size() != 0 || err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_stray: writes=%0d tx=%0d err=%b, need 0 0 1", wr_adr.size(), tx_q.size(), err);
        end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [19:0] base;
        clear_logs();
        base = 20'($urandom);
        make_frame(base, 3, 1'b0);
        ack_delay = 60;
        // SYNC, header, and two words; the second word lands while the first write is pending.
        send_range(0, 9);
        wait_resp(ok);
        ack_delay = 2;
        total++;
        if (wr_adr.size() != 1 || wr_adr[0] !== ex_adr[0] || wr_dat[0] !== ex_dat[0] || req !== 1'b0) begin
            bad++;
            $display("FAIL overrun_writes: writes=%0d %h=%h req=%b, need 1 %h=%h req 0",
                     wr_adr.size(), wr_adr[0], wr_dat[0], req, ex_adr[0], ex_dat[0]);
        end
        total++;
        if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h15 || {done, hold_cpu, err} !== 3'b011) begin
            bad++;
            $display("FAIL overrun_nak: tx=%0d first %h done/hold/err=%b%b%b, need one 15 and 011",
                     tx_q.size(), tx_q[0], done, hold_cpu, err);
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        bit seen;
        int nb;
        clear_logs();
        make_frame(20'($urandom), 2, 1'b0);
        ack_delay = 1000;
        send_range(0, 7);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL midreset_req: req never rose, need 1");
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({req, rw, adr, dtw, hold_cpu, done, err, tx_new} !== {1'b0, 1'b0, 20'h0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_async: req=%b rw=%b adr=%h dtw=%h hold=%b done=%b err=%b, need 0 0 0 0 1 0 0",
                     req, rw, adr, dtw, hold_cpu, done, err);
        end
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 2;
        repeat (5) @(negedge clk);
        clear_logs();
        make_frame(20'($urandom), 2, 1'b0);
        send_range(0, fb.size() - 1);
        wait_resp(ok);
        nb = 0;
        if (wr_adr.size() != ex_adr.size()) nb = 1;
        else foreach (ex_adr[i]) if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i]) nb++;
        total++;
        if (nb != 0 || !ok || tx_q[0] !== 8'h06 || done !== 1'b1) begin
            bad++;
            $display("FAIL midreset_reload: writes=%0d bad=%0d tx=%h done=%b, need %0d 0 06 1",
                     wr_adr.size(), nb, tx_q[0], done, ex_adr.size());
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit corrupt;
        int nb;
        logic [7:0] want;
        for (int f = 0; f < 5; f++) begin
            clear_logs();
            corrupt = 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(0, 3);
            make_frame(20'($urandom), $urandom_range(1, 4), corrupt);
            send_byte(fb[0], 0);
            total++;
            if (hold_cpu !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL b2b_sync[%0d]: hold/done/err=%b%b%b, need 100", f, hold_cpu, done, err);
            end
            send_range(1, fb.size() - 1);
            wait_resp(ok);
            nb = 0;
            if (wr_adr.size() != ex_adr.size()) nb = 1;
            else foreach (ex_adr[i]) if (wr_adr[i] !== ex_adr[i] || wr_dat[i] !== ex_dat[i]) nb++;
            want = corrupt ? 8'h15 : 8'h06;
            total++;
            if (nb != 0 || stab_bad != 0 || rw_bad != 0) begin
                bad++;
                $display("FAIL b2b_writes[%0d]: writes=%0d need %0d, wrong=%0d unstable=%0d rw_low=%0d",
                         f, wr_adr.size(), ex_adr.size(), nb, stab_bad, rw_bad);
            end
            total++;
            if (!ok || tx_q.size() != 1 || tx_q[0] !== want ||
                {done, hold_cpu, err} !== (corrupt ? 3'b011 : 3'b100)) begin
                bad++;
                $display("FAIL b2b_resp[%0d]: tx=%0d first %h done/hold/err=%b%b%b, need one %h",
                         f, tx_q.size(), tx_q[0], done, hold_cpu, err, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_bad_csum();
        test_wrap();
        test_timeout();
        test_overrun();
        test_reset_mid_write();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
